// File: rtl/sample_dut.sv
// AXI write-address channel slave: buffers accepted AW commands in an in-order FIFO,
// tags each with a 4 KB boundary-crossing flag and presents them on a valid/ready port.
module sample_dut #(
   parameter int ID_W       = 4,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 8,
   parameter int BEAT_BYTES = 4,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_W-1:0]         awid,
   input  logic [ADDR_W-1:0]       awaddr,
   input  logic [LEN_W-1:0]        awlen,
   input  logic                    awvalid,
   output logic                    awready,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [ID_W-1:0]         cmd_id,
   output logic [ADDR_W-1:0]       cmd_addr,
   output logic [LEN_W-1:0]        cmd_len,
   output logic                    cmd_cross_4k,
   output logic [15:0]             accept_count,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int SUM_W   = ADDR_W + LEN_W + 1;
   localparam int BEAT_SH = $clog2(BEAT_BYTES);

   logic [ID_W-1:0]   idMem_q    [DEPTH];
   logic [ADDR_W-1:0] addrMem_q  [DEPTH];
   logic [LEN_W-1:0]  lenMem_q   [DEPTH];
   logic              crossMem_q [DEPTH];

   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [15:0]      acceptCnt_q, acceptCnt_d;
   logic             awready_q, awready_d;

   logic             push;
   logic             pop;
   logic             crossNew;
   logic [SUM_W-1:0] burstBytes;
   logic [SUM_W-1:0] lastAddr;

   // Wide enough that a burst running off the top of the address space shows up as a crossing.
   always_comb begin
      burstBytes = (SUM_W'(awlen) + SUM_W'(1)) << BEAT_SH;
      lastAddr   = SUM_W'(awaddr) + burstBytes - SUM_W'(1);
      crossNew   = (lastAddr >> 12) != (SUM_W'(awaddr) >> 12);
   end

   assign push = awvalid && awready_q;
   assign pop  = (level_q != '0) && cmd_ready;

   always_comb begin
      wrPtr_d     = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d     = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      acceptCnt_d = push ? acceptCnt_q + 16'd1 : acceptCnt_q;
      level_d     = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
      awready_d = (level_d < LVL_W'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         level_q     <= '0;
         acceptCnt_q <= '0;
         awready_q   <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         level_q     <= level_d;
         acceptCnt_q <= acceptCnt_d;
         awready_q   <= awready_d;
      end
   end

   // Storage is cleared on reset so the head outputs read as zero while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            idMem_q[i]    <= '0;
            addrMem_q[i]  <= '0;
            lenMem_q[i]   <= '0;
            crossMem_q[i] <= 1'b0;
         end
      end else if (push) begin
         idMem_q[wrPtr_q]    <= awid;
         addrMem_q[wrPtr_q]  <= awaddr;
         lenMem_q[wrPtr_q]   <= awlen;
         crossMem_q[wrPtr_q] <= crossNew;
      end
   end

   assign awready      = awready_q;
   assign cmd_valid    = (level_q != '0);
   assign cmd_id       = idMem_q[rdPtr_q];
   assign cmd_addr     = addrMem_q[rdPtr_q];
   assign cmd_len      = lenMem_q[rdPtr_q];
   assign cmd_cross_4k = crossMem_q[rdPtr_q];
   assign accept_count = acceptCnt_q;
   assign fifo_level   = level_q;

endmodule

// File: tb/tb_sample_dut.sv
// Directed bench for sample_dut: reset, single command, 4 KB flag, fill/drain ordering,
// simultaneous push/pop and asynchronous mid-operation reset.
module tb_sample_dut;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [3:0]  cmd_id;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        cmd_cross_4k;
   logic [15:0] accept_count;
   logic [2:0]  fifo_level;

   int total = 0;
   int bad   = 0;
   int expAccept = 0;

   logic [3:0]  tId   [10];
   logic [31:0] tAddr [10];
   logic [7:0]  tLen  [10];
   int          expQ  [$];

   sample_dut #(
      .ID_W(4), .ADDR_W(32), .LEN_W(8), .BEAT_BYTES(4), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_cross_4k(cmd_cross_4k),
      .accept_count(accept_count), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One accepted AW handshake; caller guarantees awready is high.
   task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      awid    = id;
      awaddr  = addr;
      awlen   = len;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      expAccept++;
   endtask

   task automatic popHead();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   initial begin
      int  k;
      int  mLevel;
      bit  mReady;
      bit  doPush;
      bit  doPop;

      for (int i = 0; i < 10; i++) begin
         tId[i]   = 4'(i + 1);
         tAddr[i] = 32'h2000 + 32'(i * 64);
         tLen[i]  = 8'(i);
      end

      // reset held for 4 cycles
      tick();
      checkOutput("rstAwready", awready, 0);
      checkOutput("rstCmdValid", cmd_valid, 0);
      checkOutput("rstAccept", accept_count, 0);
      checkOutput("rstLevel", fifo_level, 0);
      repeat (3) tick();
      checkOutput("awreadyInReset", awready, 0);
      rst = 1'b0;
      #1;
      checkOutput("awreadyAtRelease", awready, 0);
      tick();
      checkOutput("awreadyAfterEdge", awready, 1);
      checkOutput("cmdValidAfterRelease", cmd_valid, 0);

      // single command
      applyStimulus(4'd3, 32'h1000, 8'd3);
      checkOutput("singleValid", cmd_valid, 1);
      checkOutput("singleId", cmd_id, 3);
      checkOutput("singleAddr", cmd_addr, 32'h1000);
      checkOutput("singleLen", cmd_len, 3);
      checkOutput("singleCross", cmd_cross_4k, 0);
      checkOutput("singleLevel", fifo_level, 1);
      checkOutput("singleAccept", accept_count, 1);
      popHead();
      checkOutput("singlePopLevel", fifo_level, 0);
      checkOutput("singlePopValid", cmd_valid, 0);

      // 4 KB boundary cases
      applyStimulus(4'd1, 32'h0000_0FF8, 8'd3);
      checkOutput("cross0FF8", cmd_cross_4k, 1);
      popHead();
      applyStimulus(4'd2, 32'h0000_0FF0, 8'd3);
      checkOutput("cross0FF0", cmd_cross_4k, 0);
      popHead();
      applyStimulus(4'd4, 32'hFFFF_FFF0, 8'd7);
      checkOutput("crossTopOfSpace", cmd_cross_4k, 1);
      popHead();
      checkOutput("crossAccept", accept_count, 16'(expAccept));

      // fill with backpressure for 10 cycles, then drain while the master keeps offering
      k = 0;
      mLevel = 0;
      mReady = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc >= 10 && k == 10 && mLevel == 0) break;
         cmd_ready = (cyc >= 10);
         awvalid   = (k < 10);
         if (k < 10) begin
            awid   = tId[k];
            awaddr = tAddr[k];
            awlen  = tLen[k];
         end
         checkOutput("fillReady", awready, mReady);
         checkOutput("fillLevel", fifo_level, mLevel);
         checkOutput("fillValid", cmd_valid, mLevel != 0);
         if (mLevel != 0) begin
            checkOutput("fillHeadId", cmd_id, tId[expQ[0]]);
            checkOutput("fillHeadAddr", cmd_addr, tAddr[expQ[0]]);
            checkOutput("fillHeadLen", cmd_len, tLen[expQ[0]]);
            checkOutput("fillHeadCross", cmd_cross_4k, 0);
         end
         doPush = (k < 10) && mReady;
         doPop  = cmd_ready && (mLevel != 0);
         tick();
         if (doPop) void'(expQ.pop_front());
         if (doPush) begin
            expQ.push_back(k);
            k++;
            expAccept++;
         end
         mLevel = mLevel + int'(doPush) - int'(doPop);
         mReady = (mLevel < DEPTH);
      end
      awvalid   = 1'b0;
      cmd_ready = 1'b0;
      checkOutput("fillDrainLevel", fifo_level, 0);
      checkOutput("fillAcceptCount", accept_count, 16'(expAccept));

      // simultaneous push and pop at level 2
      applyStimulus(4'd5, 32'h3000, 8'd0);
      applyStimulus(4'd6, 32'h3100, 8'd1);
      checkOutput("ppLevelBefore", fifo_level, 2);
      awid      = 4'd7;
      awaddr    = 32'h3200;
      awlen     = 8'd2;
      awvalid   = 1'b1;
      cmd_ready = 1'b1;
      checkOutput("ppHeadBefore", cmd_id, 5);
      tick();
      expAccept++;
      awvalid   = 1'b0;
      cmd_ready = 1'b0;
      checkOutput("ppLevelAfter", fifo_level, 2);
      checkOutput("ppHeadAfter", cmd_id, 6);
      checkOutput("ppAccept", accept_count, 16'(expAccept));
      popHead();
      checkOutput("ppAppendedId", cmd_id, 7);
      checkOutput("ppAppendedAddr", cmd_addr, 32'h3200);
      checkOutput("ppAppendedLen", cmd_len, 2);
      popHead();
      checkOutput("ppEmpty", fifo_level, 0);

      // asynchronous reset with commands buffered
      applyStimulus(4'd8, 32'h4000, 8'd0);
      applyStimulus(4'd9, 32'h4040, 8'd0);
      applyStimulus(4'd10, 32'h4080, 8'd0);
      checkOutput("preRstLevel", fifo_level, 3);
      checkOutput("preRstAccept", accept_count, 16'(expAccept));
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midRstValid", cmd_valid, 0);
      checkOutput("midRstLevel", fifo_level, 0);
      checkOutput("midRstAccept", accept_count, 0);
      checkOutput("midRstAwready", awready, 0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("postRstAwready", awready, 1);
      checkOutput("postRstValid", cmd_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
